// File: rtl/rr_arb_mux_reg.sv
// N-to-1 valid/ready mux: round-robin or fixed-priority arbitration into a one-word output register.
// Latency: 1 cycle from accept (in_ready) to out_valid; one word per cycle when out_ready is held.
// Backpressure: out_valid && !out_ready freezes the output word, sel and pointer, and drops every in_ready.
module rr_arb_mux_reg #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  grant;
    logic [N-1:0]     hi_req;
    logic [N-1:0]     gnt_oh;
    logic [WIDTH-1:0] sel_data;
    logic             gnt_v;
    logic             load;

    function automatic logic [SELW-1:0] lowest_set(input logic [N-1:0] v);
        logic [SELW-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = SELW'(i);
        end
        return r;
    endfunction

    assign load  = !out_valid || out_ready;
    assign gnt_v = |in_valid;

    // Round-robin as two priority passes: requesters above the last grant first,
    // then wrap to the lowest requester overall (which may be ptr itself).
    always_comb begin
        hi_req = '0;
        for (int i = 0; i < N; i++) begin
            hi_req[i] = in_valid[i] && (i > int'(ptr));
        end
        if (!mode && (|hi_req)) grant = lowest_set(hi_req);
        else                    grant = lowest_set(in_valid);
    end

    always_comb begin
        gnt_oh   = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            gnt_oh[i] = gnt_v && (grant == SELW'(i));
            sel_data  = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt_oh[i]}});
        end
    end

    assign in_ready = load ? gnt_oh : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= SELW'(N - 1);
        end else if (load) begin
            if (gnt_v) begin
                out_data  <= sel_data;
                out_sel   <= grant;
                out_valid <= 1'b1;
                ptr       <= grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux_reg.sv
// Bench for rr_arb_mux_reg: an N=8/WIDTH=32 and an N=5/WIDTH=16 instance share one stimulus stream.
// A queue-based reference model predicts grants and words; per-instance monitors check the output side.
module tb_rr_arb_mux_reg;

    logic         clock = 1'b0;
    logic         reset;
    logic         mode;
    logic         out_ready;
    logic [7:0]   in_valid;
    logic [255:0] in_data_a;
    logic [79:0]  in_data_b;

    logic [7:0]   in_ready_a;
    logic [31:0]  out_data_a;
    logic [2:0]   out_sel_a;
    logic         out_valid_a;
    logic [4:0]   in_ready_b;
    logic [15:0]  out_data_b;
    logic [2:0]   out_sel_b;
    logic         out_valid_b;

    always #5 clock = ~clock;

    always_comb begin
        in_data_b = '0;
        for (int i = 0; i < 5; i++) in_data_b[i*16 +: 16] = in_data_a[i*32 +: 16];
    end

    rr_arb_mux_reg #(.WIDTH(32), .N(8)) dut_a (
        .clock(clock), .reset(reset), .mode(mode),
        .in_data(in_data_a), .in_valid(in_valid), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_sel(out_sel_a), .out_valid(out_valid_a),
        .out_ready(out_ready)
    );

    rr_arb_mux_reg #(.WIDTH(16), .N(5)) dut_b (
        .clock(clock), .reset(reset), .mode(mode),
        .in_data(in_data_b), .in_valid(in_valid[4:0]), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_sel(out_sel_b), .out_valid(out_valid_b),
        .out_ready(out_ready)
    );

    typedef struct {
        logic [31:0] d;
        int          s;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;
    int   nch[2]   = '{8, 5};
    int   m_ptr[2];
    bit   m_ov[2];
    bit   m_zero[2];
    bit   armed[2] = '{1'b0, 1'b0};

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Spec-level rule: round-robin searches ptr+1, ptr+2, ... mod n; fixed priority takes the lowest index.
    function automatic int exp_grant(input int n, input logic [7:0] v, input int ptr, input bit md);
        int idx;
        if (md) begin
            for (int i = 0; i < n; i++) if (v[i]) return i;
        end else begin
            for (int k = 1; k <= n; k++) begin
                idx = (ptr + k) % n;
                if (v[idx]) return idx;
            end
        end
        return -1;
    endfunction

    task automatic model_inst(input int inst, input logic ov, input logic [31:0] od,
                              input int os, input logic [7:0] ir);
        int          n;
        int          g;
        bit          ld;
        logic [7:0]  v;
        logic [7:0]  er;
        exp_t        e;
        n = nch[inst];
        if (armed[inst]) begin
            check("out_valid", inst, {31'd0, ov}, {31'd0, m_ov[inst]});
            if (m_zero[inst]) begin
                check("reset_data", inst, od, 32'd0);
                check("reset_sel", inst, os, 32'd0);
                m_zero[inst] = 1'b0;
            end
        end
        v = '0;
        for (int i = 0; i < n; i++) v[i] = in_valid[i];
        g  = exp_grant(n, v, m_ptr[inst], mode);
        ld = !m_ov[inst] || out_ready;
        er = (ld && g >= 0) ? (8'd1 << g) : 8'd0;
        if (reset) begin
            m_ptr[inst]  = n - 1;
            m_ov[inst]   = 1'b0;
            m_zero[inst] = 1'b1;
            armed[inst]  = 1'b1;
            if (inst == 0) q0.delete(); else q1.delete();
        end else if (armed[inst]) begin
            check("in_ready", inst, {24'd0, ir}, {24'd0, er});
            if (ld) begin
                if (g >= 0) begin
                    e.d = in_data_a[g*32 +: 32];
                    if (inst == 1) e.d = {16'd0, e.d[15:0]};
                    e.s = g;
                    if (inst == 0) q0.push_back(e); else q1.push_back(e);
                    m_ov[inst]  = 1'b1;
                    m_ptr[inst] = g;
                end else begin
                    m_ov[inst] = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic md, input logic [7:0] v,
                        input logic ordy, input bit tags);
        @(posedge clock);
        #1;
        reset     = r;
        mode      = md;
        in_valid  = v;
        out_ready = ordy;
        for (int i = 0; i < 8; i++)
            in_data_a[i*32 +: 32] = tags ? (32'hA5A5_0000 + 32'(i) * 32'h0001_0101) : $urandom;
        @(negedge clock);
        model_inst(0, out_valid_a, out_data_a, int'(out_sel_a), in_ready_a);
        model_inst(1, out_valid_b, {16'd0, out_data_b}, int'(out_sel_b), {3'd0, in_ready_b});
    endtask

    // Output monitors: the head of each queue must be on the output while valid,
    // and is retired only on a handshake.
    always @(negedge clock) begin
        if (armed[0] && !reset && out_valid_a) begin
            if (q0.size() == 0) check("mon_empty", 0, 32'd1, 32'd0);
            else begin
                check("out_data", 0, out_data_a, q0[0].d);
                check("out_sel", 0, {29'd0, out_sel_a}, q0[0].s);
                if (out_ready) void'(q0.pop_front());
            end
        end
    end

    always @(negedge clock) begin
        if (armed[1] && !reset && out_valid_b) begin
            if (q1.size() == 0) check("mon_empty", 1, 32'd1, 32'd0);
            else begin
                check("out_data", 1, {16'd0, out_data_b}, q1[0].d);
                check("out_sel", 1, {29'd0, out_sel_b}, q1[0].s);
                if (out_ready) void'(q1.pop_front());
            end
        end
    end

    initial begin
        reset     = 1'b1;
        mode      = 1'b0;
        out_ready = 1'b0;
        in_valid  = '0;
        in_data_a = '0;

        // Reset, then all channels valid in round-robin: 0..7,0 on dut_a.
        step(1, 0, 8'h00, 1, 1);
        step(1, 0, 8'hFF, 1, 1);
        for (int k = 0; k < 10; k++) step(0, 0, 8'hFF, 1, 1);

        // Fixed priority with 1010_0100 held: channel 2 always.
        for (int k = 0; k < 6; k++) step(0, 1, 8'hA4, 1, 1);

        // Stall for 5 cycles with changing valids, then release.
        for (int k = 0; k < 5; k++) step(0, 0, 8'($urandom), 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 8'hFF, 1, 0);

        // Last grant on channel 7, then 7 and 3 valid: 3 then 7.
        step(0, 0, 8'h80, 1, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 8'h88, 1, 1);

        // No requests while draining: out_valid falls, data holds.
        for (int k = 0; k < 3; k++) step(0, 0, 8'h00, 1, 1);

        // Reset while the output is full and requests are pending.
        step(0, 0, 8'hFF, 1, 1);
        step(0, 0, 8'hFF, 0, 1);
        step(1, 0, 8'hFF, 1, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 8'hFF, 1, 1);

        for (int k = 0; k < 2000; k++) begin
            logic [7:0] v;
            v = ($urandom_range(1) == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
            step(($urandom_range(99) == 0), ($urandom_range(3) == 0), v,
                 ($urandom_range(3) != 0), 0);
        end

        for (int k = 0; k < 4; k++) step(0, 0, 8'h00, 1, 0);
        check("drain", 0, q0.size(), 32'd0);
        check("drain", 1, q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
